// File: rtl/conv3x3_mac.sv
// 3x3 convolution MAC: one time-shared signed multiplier, 9 MAC cycles per window, 8-bit pixel out.
// Define CONV_SAT_EN to clamp the output pixel to 0..255; otherwise the low 8 bits wrap.
module conv3x3_mac #(
  parameter int WIDTH     = 9,
  parameter int ACC_WIDTH = 22,
  parameter int SHIFT     = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    window_valid,
  input  logic [9*WIDTH-1:0]      window,
  output logic                    in_ready,
  input  logic                    coef_we,
  input  logic [3:0]              coef_addr,
  input  logic signed [WIDTH-1:0] coef_data,
  output logic [7:0]              pixel_out,
  output logic                    pixel_valid,
  output logic                    overrun
);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  localparam logic signed [ACC_WIDTH-1:0] PIX_MAX = ACC_WIDTH'(255);

  state_t                        state;
  logic signed [WIDTH-1:0]       win_lat [9];
  logic signed [WIDTH-1:0]       coef    [9];
  logic [3:0]                    k;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [2*WIDTH-1:0]     prod;
  logic signed [ACC_WIDTH-1:0]   prod_ext;
  logic signed [ACC_WIDTH-1:0]   shifted;

  function automatic logic [7:0] to_pixel(input logic signed [ACC_WIDTH-1:0] r);
`ifdef CONV_SAT_EN
    if (r[ACC_WIDTH-1])
      return 8'd0;
    else if (r > PIX_MAX)
      return 8'd255;
    else
      return r[7:0];
`else
    return r[7:0];
`endif
  endfunction

  assign prod     = win_lat[k] * coef[k];
  assign prod_ext = {{(ACC_WIDTH-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  assign shifted  = acc >>> SHIFT;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      k           <= '0;
      acc         <= '0;
      pixel_out   <= '0;
      pixel_valid <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < 9; i++)
        coef[i] <= (i == 4) ? WIDTH'(1) : '0;
    end else begin
      pixel_valid <= 1'b0;
      if (window_valid && state != IDLE)
        overrun <= 1'b1;
      case (state)
        // Idle: accept coefficient writes and the next window
        IDLE: begin
          if (coef_we && coef_addr <= 4'd8)
            coef[coef_addr] <= coef_data;
          if (window_valid) begin
            for (int i = 0; i < 9; i++)
              win_lat[i] <= $signed(window[i*WIDTH +: WIDTH]);
            acc      <= '0;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= MAC;
          end
        end
        // Mac: one product per cycle, k walks 0..8
        MAC: begin
          acc <= acc + prod_ext;
          k   <= k + 4'd1;
          if (k == 4'd8)
            state <= OUT;
        end
        // Out: shift, convert and publish the pixel
        OUT: begin
          pixel_out   <= to_pixel(shifted);
          pixel_valid <= 1'b1;
          in_ready    <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv3x3_mac.sv
// Self-checking bench for conv3x3_mac: directed kernels plus random windows against a sum-of-products model.
module tb_conv3x3_mac;
  localparam int W  = 9;
  localparam int AW = 22;
  localparam int SH = 0;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             window_valid = 1'b0;
  logic [9*W-1:0]   window = '0;
  logic             in_ready;
  logic             coef_we = 1'b0;
  logic [3:0]       coef_addr = '0;
  logic signed [W-1:0] coef_data = '0;
  logic [7:0]       pixel_out;
  logic             pixel_valid;
  logic             overrun;

  int errors = 0;
  int checks = 0;
  int coef_m [9];

  conv3x3_mac #(.WIDTH(W), .ACC_WIDTH(AW), .SHIFT(SH)) dut (
    .clk(clk), .reset(reset), .window_valid(window_valid), .window(window),
    .in_ready(in_ready), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .pixel_out(pixel_out), .pixel_valid(pixel_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: sum of products, arithmetic shift, then clamp or wrap to 8 bits
  function automatic int model_pixel(input int w[9]);
    int s;
    int r;
    s = 0;
    for (int i = 0; i < 9; i++) s += w[i] * coef_m[i];
    r = s >>> SH;
`ifdef CONV_SAT_EN
    if (r < 0) return 0;
    if (r > 255) return 255;
    return r;
`else
    return r & 255;
`endif
  endfunction

  function automatic int rand_s9();
    return int'($urandom_range(0, 511)) - 256;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_window(input int w[9]);
    for (int i = 0; i < 9; i++) window[i*W +: W] = W'(w[i]);
    window_valid = 1'b1;
    tick();
    window_valid = 1'b0;
  endtask

  task automatic write_coef(input int addr, input int val);
    coef_we   = 1'b1;
    coef_addr = 4'(addr);
    coef_data = W'(val);
    tick();
    coef_we   = 1'b0;
  endtask

  // lat = number of clock edges after the accepting edge until pixel_valid is seen
  task automatic wait_pixel(output int lat, output int px, output bit got);
    got = 1'b0; lat = 0; px = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (pixel_valid) begin
        got = 1'b1; lat = i; px = int'(pixel_out);
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    window_valid = 1'b1;
    tick(); tick();
    reset = 1'b0;
    window_valid = 1'b0;
    coef_m = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (pixel_out !== 8'd0) begin errors++; $display("FAIL reset_pixel_out: got %0d want 0", pixel_out); end
    checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_pixel_valid: got %b want 0", pixel_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    tick(); tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_window_ignored: in_ready %b want 1", in_ready); end
  endtask

  task automatic test_identity();
    int w[9];
    bit exp_rdy, exp_pv;
    for (int i = 0; i < 9; i++) w[i] = i;
    send_window(w);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ident_in_ready_t0: got %b want 0", in_ready); end
    for (int i = 1; i <= 11; i++) begin
      tick();
      exp_rdy = (i >= 10);
      exp_pv  = (i == 10);
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL ident_in_ready@%0d: got %b want %b", i, in_ready, exp_rdy); end
      checks++; if (pixel_valid !== exp_pv) begin errors++; $display("FAIL ident_pixel_valid@%0d: got %b want %b", i, pixel_valid, exp_pv); end
      if (i >= 10) begin
        checks++; if (pixel_out !== 8'd4) begin errors++; $display("FAIL ident_pixel@%0d: got %0d want 4", i, pixel_out); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int w1[9], w2[9];
    int lat, px;
    bit got;
    for (int i = 0; i < 9; i++) begin w1[i] = 10 + i; w2[i] = 40 - i; end
    send_window(w1);
    wait_pixel(lat, px, got);
    checks++; if (!got || px != model_pixel(w1)) begin errors++; $display("FAIL b2b_first: got %0d (seen %b) want %0d", px, got, model_pixel(w1)); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
    send_window(w2);
    wait_pixel(lat, px, got);
    checks++; if (!got || lat != 10) begin errors++; $display("FAIL b2b_latency: got %0d (seen %b) want 10", lat, got); end
    checks++; if (px != model_pixel(w2)) begin errors++; $display("FAIL b2b_second: got %0d want %0d", px, model_pixel(w2)); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_all_ones();
    int w[9];
    int lat, px, want;
    bit got;
    for (int a = 0; a < 9; a++) begin write_coef(a, 1); coef_m[a] = 1; end
    for (int i = 0; i < 9; i++) w[i] = 30;
`ifdef CONV_SAT_EN
    want = 255;
`else
    want = 14;
`endif
    send_window(w);
    wait_pixel(lat, px, got);
    checks++; if (!got || px != want) begin errors++; $display("FAIL all_ones_270: got %0d (seen %b) want %0d", px, got, want); end
  endtask

  task automatic test_laplacian();
    int w[9];
    int lat, px, want;
    bit got;
    for (int a = 0; a < 9; a++) begin
      coef_m[a] = (a == 4) ? 8 : -1;
      write_coef(a, coef_m[a]);
    end
    w = '{0, 0, 0, 0, 10, 0, 0, 0, 0};
    send_window(w);
    wait_pixel(lat, px, got);
    checks++; if (!got || px != 80) begin errors++; $display("FAIL lap_centre10: got %0d want 80", px); end
    for (int i = 0; i < 9; i++) w[i] = 20;
    send_window(w);
    wait_pixel(lat, px, got);
    checks++; if (!got || px != 0) begin errors++; $display("FAIL lap_flat20: got %0d want 0", px); end
    w = '{5, 5, 5, 5, 0, 5, 5, 5, 5};
`ifdef CONV_SAT_EN
    want = 0;
`else
    want = 216;
`endif
    send_window(w);
    wait_pixel(lat, px, got);
    checks++; if (!got || px != want) begin errors++; $display("FAIL lap_neg40: got %0d want %0d", px, want); end
  endtask

  task automatic test_coef_same_cycle();
    int w[9];
    int lat, px;
    bit got;
    coef_m = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    for (int a = 0; a < 9; a++) write_coef(a, coef_m[a]);
    write_coef(12, 77);
    w = '{0, 0, 0, 0, 50, 0, 0, 0, 0};
    for (int i = 0; i < 9; i++) window[i*W +: W] = W'(w[i]);
    coef_we = 1'b1; coef_addr = 4'd4; coef_data = W'(2);
    window_valid = 1'b1;
    tick();
    coef_we = 1'b0; window_valid = 1'b0;
    coef_m[4] = 2;
    wait_pixel(lat, px, got);
    checks++; if (!got || px != 100) begin errors++; $display("FAIL same_cycle_write: got %0d want 100", px); end
    for (int i = 0; i < 9; i++) w[i] = 1;
    send_window(w);
    wait_pixel(lat, px, got);
    checks++; if (!got || px != model_pixel(w)) begin errors++; $display("FAIL addr12_ignored: got %0d want %0d", px, model_pixel(w)); end
  endtask

  task automatic test_random();
    int w[9];
    int lat, px;
    bit got;
    for (int n = 0; n < 16; n++) begin
      if (n % 4 == 0)
        for (int a = 0; a < 9; a++) begin coef_m[a] = rand_s9(); write_coef(a, coef_m[a]); end
      for (int i = 0; i < 9; i++) w[i] = rand_s9();
      send_window(w);
      wait_pixel(lat, px, got);
      checks++; if (!got || lat != 10) begin errors++; $display("FAIL rand_latency[%0d]: got %0d (seen %b) want 10", n, lat, got); end
      checks++; if (px != model_pixel(w)) begin errors++; $display("FAIL rand_pixel[%0d]: got %0d want %0d", n, px, model_pixel(w)); end
    end
  endtask

  task automatic test_overrun();
    int w[9], w2[9];
    int pulses, px;
    for (int i = 0; i < 9; i++) begin w[i] = rand_s9(); w2[i] = rand_s9(); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre: got %b want 0", overrun); end
    send_window(w);
    tick(); tick();
    for (int i = 0; i < 9; i++) window[i*W +: W] = W'(w2[i]);
    window_valid = 1'b1;
    tick();
    window_valid = 1'b0;
    pulses = 0; px = -1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (pixel_valid) begin pulses++; px = int'(pixel_out); end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL overrun_pulses: got %0d want 1", pulses); end
    checks++; if (px != model_pixel(w)) begin errors++; $display("FAIL overrun_pixel: got %0d want %0d", px, model_pixel(w)); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b want 1", overrun); end
  endtask

  task automatic test_coef_during_mac();
    int w[9];
    int lat, px;
    bit got;
    write_coef(4, 1); coef_m[4] = 1;
    for (int i = 0; i < 9; i++) w[i] = 2 * i - 7;
    send_window(w);
    tick(); tick();
    write_coef(4, 99);
    wait_pixel(lat, px, got);
    checks++; if (!got || px != model_pixel(w)) begin errors++; $display("FAIL mac_write_cur: got %0d want %0d", px, model_pixel(w)); end
    w = '{0, 0, 0, 0, 3, 0, 0, 0, 0};
    send_window(w);
    wait_pixel(lat, px, got);
    checks++; if (!got || px != model_pixel(w)) begin errors++; $display("FAIL mac_write_dropped: got %0d want %0d", px, model_pixel(w)); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL mac_write_overrun: got %b want 1", overrun); end
  endtask

  task automatic test_reset_mid_mac();
    int w[9];
    int lat, px, pulses;
    bit got;
    for (int i = 0; i < 9; i++) w[i] = 60;
    send_window(w);
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    coef_m = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midmac_in_ready: got %b want 1", in_ready); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midmac_overrun: got %b want 0", overrun); end
    checks++; if (pixel_out !== 8'd0) begin errors++; $display("FAIL midmac_pixel_out: got %0d want 0", pixel_out); end
    pulses = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (pixel_valid) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midmac_no_pulse: got %0d want 0", pulses); end
    for (int i = 0; i < 9; i++) w[i] = 7;
    send_window(w);
    wait_pixel(lat, px, got);
    checks++; if (!got || px != 7) begin errors++; $display("FAIL midmac_identity: got %0d (seen %b) want 7", px, got); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_back_to_back();
    test_all_ones();
    test_laplacian();
    test_coef_same_cycle();
    test_random();
    test_overrun();
    test_coef_during_mac();
    test_reset_mid_mac();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
